device_req_master: RTL and testbench
====================================

Name: device_req_master

Overview:
- Initiator side of the simulation device-helper interface; the helper itself is the responder.
- Accepts MMIO requests from the uncore on a valid/ready channel and range-checks them against the device window.
- Drives a one-cycle device request strobe, then captures read data on the following cycle.
- Returns responses on a valid/ready channel through a small response FIFO, so core back-pressure never stalls the device side.

Parameters:
- BASE_ADDR, 64'h4060_0000: start of the device address window (inclusive).
- SIZE, 64'h0001_0000: window size in bytes. A request hits when BASE_ADDR <= addr < BASE_ADDR+SIZE.
- ID_W, 4: width of the request/response tag.
- RESP_DEPTH, 2: response FIFO entries; must be >= 1.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  upstream request valid
- req_ready  out  1  upstream request ready
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  64  byte address
- req_wdata  in  64  write data
- req_wmask  in  8  byte write mask
- req_id  in  ID_W  request tag
- resp_valid  out  1  response valid
- resp_ready  in  1  response ready
- resp_rdata  out  64  read data; 0 for writes and errors
- resp_id  out  ID_W  echoed tag
- resp_err  out  1  1 = address outside the window
- dev_req_valid  out  1  device request strobe, one cycle wide
- dev_req_wen  out  1  device write enable
- dev_req_addr  out  64  device address, passed through unaligned
- dev_req_wdata  out  64  device write data
- dev_req_wmask  out  8  device byte mask
- dev_resp_rdata  in  64  device read data, valid in the cycle after dev_req_valid

Behaviour:
- Reset (reset_n=0 at posedge):
  - FSM goes to IDLE; FIFO is emptied (head, tail, count = 0).
  - dev_req_valid=0; dev_req_* data registers=0.
  - req_ready is forced 0 while reset_n=0. resp_valid=0.
  - Reset mid-operation drops any in-flight request with no response.
- FSM states IDLE, ISSUE, CAPTURE. At most one request is in flight.
- req_ready = reset_n && state==IDLE && fifo_count < RESP_DEPTH.
  - This is combinational from registers only; it never depends on req_valid.
- IDLE, on accept (req_valid && req_ready):
  - Latch wen, addr, wdata, wmask and id.
  - Hit → go to ISSUE.
  - Miss → push {rdata=0, id, err=1} into the FIFO at the same edge and stay in IDLE. No device request is issued.
- ISSUE:
  - dev_req_valid=1 for exactly this cycle; dev_req_* hold the latched values.
  - Go to CAPTURE unconditionally.
- CAPTURE:
  - Push {rdata = wen ? 0 : dev_resp_rdata, id, err=0}.
  - Go to IDLE.
  - Push always succeeds, because space was reserved at accept.
- Latency and throughput:
  - Hit: accept edge → resp_valid visible 3 cycles later (ISSUE, CAPTURE, FIFO output).
  - Miss: resp_valid visible in the cycle after accept.
  - Sustained hit throughput is 1 request per 3 cycles.
- Response FIFO:
  - resp_* is driven from the head entry; resp_valid = count != 0.
  - Pop when resp_valid && resp_ready.
  - Simultaneous push and pop leaves count unchanged; ordering is preserved.
  - Pointers wrap modulo RESP_DEPTH; RESP_DEPTH need not be a power of two.
- Address arithmetic:
  - Compare as 65-bit unsigned, so BASE_ADDR+SIZE cannot overflow.
  - An addr equal to BASE_ADDR+SIZE is a miss.
- dev_req_* data outputs may hold stale values while dev_req_valid=0.
- Upstream request fields must be stable only in the accept cycle.

Decomposition:
- Shared package dev_bus_pkg holds:
  - typedef dev_req_t {wen, addr[63:0], wdata[63:0], wmask[7:0]}
  - typedef dev_resp_t {rdata[63:0], err}
  - localparams DEV_DATA_W=64 and DEV_MASK_W=8
  - FSM state enum
- One sub-module: dev_resp_fifo, a parameterised synchronous FIFO (depth, payload width, synchronous active-low reset).

Test Plan:
- Read hit: req addr=0x4060_0008, wen=0, id=3; helper returns 0xDEAD_BEEF_0000_1234 → dev_req_valid high for exactly 1 cycle with addr=0x4060_0008; 3 cycles after accept resp_valid=1, rdata=0xDEAD_BEEF_0000_1234, id=3, err=0.
- Write hit: addr=0x4060_0010, wdata=0x1122_3344_5566_7788, wmask=0x0F, id=5 → dev_req_wen=1 with matching data and mask; resp rdata=0, err=0, id=5.
- Miss, both sides of the window: addr=0x4061_0000 and 0x405F_FFF8 → dev_req_valid never asserts; resp err=1, rdata=0, one cycle after accept.
- Back-pressure: hold resp_ready=0 and issue 3 reads → the first 2 complete, then req_ready stays 0; release resp_ready → responses drain in order, then the third request is accepted.
- Simultaneous push and pop: resp_ready=1 with a miss request every IDLE cycle → count never exceeds 1, req_ready stays 1, and ids come out in order.
- Reset mid-flight: assert reset_n=0 during CAPTURE → next cycle resp_valid=0 and req_ready=0; after release, req_ready=1 and no stale response appears.

Source files
------------

// File: rtl/dev_bus_pkg.sv
// Shared types for the device-helper request/response path.
package dev_bus_pkg;

  localparam int unsigned DEV_DATA_W = 64;
  localparam int unsigned DEV_MASK_W = 8;
  localparam int unsigned DEV_ADDR_W = 64;

  typedef struct packed {
    logic                  wen;
    logic [DEV_ADDR_W-1:0] addr;
    logic [DEV_DATA_W-1:0] wdata;
    logic [DEV_MASK_W-1:0] wmask;
  } dev_req_t;

  typedef struct packed {
    logic [DEV_DATA_W-1:0] rdata;
    logic                  err;
  } dev_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE
  } state_e;

endpackage

// File: rtl/dev_resp_fifo.sv
// Synchronous FIFO with modulo-DEPTH pointers; DEPTH need not be a power of two.
module dev_resp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic             push_en;
  logic             pop_en;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign pop_en  = pop && (count_q != '0);
  assign push_en = push && ((count_q != CNT_W'(DEPTH)) || pop_en);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) tail_q <= ptr_next(tail_q);
      if (pop_en)  head_q <= ptr_next(head_q);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[tail_q] <= push_data;
  end

  assign pop_data = mem_q[head_q];
  assign count    = count_q;

endmodule

// File: rtl/device_req_master.sv
// Initiator side of the device-helper interface: range-checks MMIO requests,
// strobes the device for one cycle and queues responses for the core.
module device_req_master
  import dev_bus_pkg::*;
#(
  parameter logic [63:0]  BASE_ADDR  = 64'h4060_0000,
  parameter logic [63:0]  SIZE       = 64'h0001_0000,
  parameter int unsigned  ID_W       = 4,
  parameter int unsigned  RESP_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [DEV_ADDR_W-1:0] req_addr,
  input  logic [DEV_DATA_W-1:0] req_wdata,
  input  logic [DEV_MASK_W-1:0] req_wmask,
  input  logic [ID_W-1:0]       req_id,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DEV_DATA_W-1:0] resp_rdata,
  output logic [ID_W-1:0]       resp_id,
  output logic                  resp_err,
  output logic                  dev_req_valid,
  output logic                  dev_req_wen,
  output logic [DEV_ADDR_W-1:0] dev_req_addr,
  output logic [DEV_DATA_W-1:0] dev_req_wdata,
  output logic [DEV_MASK_W-1:0] dev_req_wmask,
  input  logic [DEV_DATA_W-1:0] dev_resp_rdata
);

  localparam int unsigned CNT_W  = $clog2(RESP_DEPTH + 1);
  localparam int unsigned RESP_W = $bits(dev_resp_t) + ID_W;
  // 65-bit window bounds so BASE_ADDR+SIZE cannot wrap.
  localparam logic [64:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [64:0] WIN_HI = {1'b0, BASE_ADDR} + {1'b0, SIZE};

  state_e            state_q;
  state_e            state_d;
  dev_req_t          req_q;
  logic [ID_W-1:0]   id_q;
  logic              accept;
  logic              hit;
  logic              push;
  dev_resp_t         push_resp;
  logic [ID_W-1:0]   push_id;
  logic [RESP_W-1:0] head;
  logic [CNT_W-1:0]  fifo_count;

  // Space for the response is reserved at accept, so CAPTURE never stalls.
  assign req_ready = reset_n && (state_q == ST_IDLE) && (fifo_count < CNT_W'(RESP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign hit       = ({1'b0, req_addr} >= WIN_LO) && ({1'b0, req_addr} < WIN_HI);

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_resp = '0;
    push_id   = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (hit) begin
            state_d = ST_ISSUE;
          end else begin
            push          = 1'b1;
            push_resp.err = 1'b1;
            push_id       = req_id;
          end
        end
      end
      ST_ISSUE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        push            = 1'b1;
        push_resp.rdata = req_q.wen ? '0 : dev_resp_rdata;
        push_id         = id_q;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      req_q         <= '0;
      id_q          <= '0;
      dev_req_valid <= 1'b0;
    end else begin
      state_q       <= state_d;
      dev_req_valid <= (state_d == ST_ISSUE);
      if (accept) begin
        req_q <= '{wen: req_wen, addr: req_addr, wdata: req_wdata, wmask: req_wmask};
        id_q  <= req_id;
      end
    end
  end

  assign dev_req_wen   = req_q.wen;
  assign dev_req_addr  = req_q.addr;
  assign dev_req_wdata = req_q.wdata;
  assign dev_req_wmask = req_q.wmask;

  dev_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (RESP_W)
  ) u_resp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({push_resp, push_id}),
    .pop       (resp_valid && resp_ready),
    .pop_data  (head),
    .count     (fifo_count)
  );

  assign resp_valid                       = (fifo_count != '0);
  assign {resp_rdata, resp_err, resp_id}  = head;

endmodule

// File: tb/tb_device_req_master.sv
// Self-checking bench: transaction-level model plus directed literal checks and random traffic.
module tb_device_req_master;

  localparam logic [63:0] BASE  = 64'h4060_0000;
  localparam logic [63:0] SIZE  = 64'h0001_0000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic [3:0]  req_id;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic [3:0]  resp_id;
  logic        resp_err;
  logic        dev_req_valid;
  logic        dev_req_wen;
  logic [63:0] dev_req_addr;
  logic [63:0] dev_req_wdata;
  logic [7:0]  dev_req_wmask;
  logic [63:0] dev_resp_rdata;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  device_req_master dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wen        (req_wen),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wmask      (req_wmask),
    .req_id         (req_id),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_id        (resp_id),
    .resp_err       (resp_err),
    .dev_req_valid  (dev_req_valid),
    .dev_req_wen    (dev_req_wen),
    .dev_req_addr   (dev_req_addr),
    .dev_req_wdata  (dev_req_wdata),
    .dev_req_wmask  (dev_req_wmask),
    .dev_resp_rdata (dev_resp_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic [63:0] rdata;
    logic [3:0]  id;
    logic        err;
  } rsp_t;

  rsp_t        mq[$];
  bit          m_busy = 1'b0;   // a hit is in flight
  int          m_age  = 0;      // cycles since its accept edge
  logic        m_wen;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wmask;
  logic [3:0]  m_id;

  function automatic bit in_window(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < SIZE);
  endfunction

  always @(posedge clk) begin
    bit   acc, pop, done;
    rsp_t r;
    acc  = req_valid && reset_n && !m_busy && (mq.size() < DEPTH);
    pop  = (mq.size() != 0) && resp_ready;
    done = m_busy && (m_age == 1);
    if (!reset_n) begin
      mq.delete();
      m_busy = 1'b0;
      m_age  = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (done) begin
        r.rdata = m_wen ? 64'h0 : dev_resp_rdata;
        r.id    = m_id;
        r.err   = 1'b0;
        mq.push_back(r);
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_age++;
      end
      if (acc) begin
        if (in_window(req_addr)) begin
          m_busy  = 1'b1;
          m_age   = 0;
          m_wen   = req_wen;
          m_addr  = req_addr;
          m_wdata = req_wdata;
          m_wmask = req_wmask;
          m_id    = req_id;
        end else begin
          r.rdata = 64'h0;
          r.id    = req_id;
          r.err   = 1'b1;
          mq.push_back(r);
        end
      end
    end
  end

  // Compare process: outputs checked mid-cycle against the model.
  always @(negedge clk) begin
    if (started) begin
      bit strobe;
      strobe = m_busy && (m_age == 0);
      chk("req_ready", 64'(req_ready), 64'(reset_n && !m_busy && (mq.size() < DEPTH)));
      chk("resp_valid", 64'(resp_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("resp_rdata", resp_rdata, mq[0].rdata);
        chk("resp_id", 64'(resp_id), 64'(mq[0].id));
        chk("resp_err", 64'(resp_err), 64'(mq[0].err));
      end
      chk("dev_req_valid", 64'(dev_req_valid), 64'(strobe));
      if (strobe) begin
        chk("dev_req_wen", 64'(dev_req_wen), 64'(m_wen));
        chk("dev_req_addr", dev_req_addr, m_addr);
        chk("dev_req_wdata", dev_req_wdata, m_wdata);
        chk("dev_req_wmask", 64'(dev_req_wmask), 64'(m_wmask));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic wen, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [7:0] wmask,
                           input logic [3:0] id);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    req_id    = id;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] pick_addr();
    int sel;
    sel = $urandom_range(0, 5);
    case (sel)
      0: return BASE + 64'($urandom_range(0, 32'hFFFF));
      1: return BASE + SIZE - 64'($urandom_range(1, 8));
      2: return BASE + SIZE + 64'($urandom_range(0, 8));
      3: return BASE - 64'($urandom_range(1, 8));
      4: return BASE;
      default: return rand64();
    endcase
  endfunction

  initial begin
    reset_n        = 1'b0;
    req_valid      = 1'b0;
    req_wen        = 1'b0;
    req_addr       = '0;
    req_wdata      = '0;
    req_wmask      = '0;
    req_id         = '0;
    resp_ready     = 1'b1;
    dev_resp_rdata = '0;
    step();
    step();
    started = 1'b1;
    chk("reset_resp_valid", 64'(resp_valid), 64'h0);
    chk("reset_req_ready", 64'(req_ready), 64'h0);
    chk("reset_dev_addr", dev_req_addr, 64'h0);
    reset_n = 1'b1;
    #1;
    chk("release_req_ready", 64'(req_ready), 64'h1);

    // Read hit
    dev_resp_rdata = 64'hDEAD_BEEF_0000_1234;
    drive_req(1'b0, 64'h4060_0008, 64'h0, 8'h00, 4'd3);
    step();
    req_valid = 1'b0;
    chk("rd_strobe", 64'(dev_req_valid), 64'h1);
    chk("rd_addr", dev_req_addr, 64'h4060_0008);
    step();
    chk("rd_strobe_one_cycle", 64'(dev_req_valid), 64'h0);
    step();
    chk("rd_resp_valid", 64'(resp_valid), 64'h1);
    chk("rd_resp_rdata", resp_rdata, 64'hDEAD_BEEF_0000_1234);
    chk("rd_resp_id", 64'(resp_id), 64'd3);
    step();

    // Write hit
    dev_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    drive_req(1'b1, 64'h4060_0010, 64'h1122_3344_5566_7788, 8'h0F, 4'd5);
    step();
    req_valid = 1'b0;
    chk("wr_wen", 64'(dev_req_wen), 64'h1);
    chk("wr_wdata", dev_req_wdata, 64'h1122_3344_5566_7788);
    chk("wr_wmask", 64'(dev_req_wmask), 64'h0F);
    step();
    step();
    chk("wr_resp_rdata", resp_rdata, 64'h0);
    chk("wr_resp_id", 64'(resp_id), 64'd5);
    chk("wr_resp_err", 64'(resp_err), 64'h0);
    step();

    // Misses just above and just below the window
    drive_req(1'b0, 64'h4061_0000, 64'h0, 8'h0, 4'd7);
    step();
    req_valid = 1'b0;
    chk("miss_hi_valid", 64'(resp_valid), 64'h1);
    chk("miss_hi_err", 64'(resp_err), 64'h1);
    chk("miss_hi_strobe", 64'(dev_req_valid), 64'h0);
    step();
    drive_req(1'b0, 64'h405F_FFF8, 64'h0, 8'h0, 4'd8);
    step();
    req_valid = 1'b0;
    chk("miss_lo_err", 64'(resp_err), 64'h1);
    chk("miss_lo_id", 64'(resp_id), 64'd8);
    step();

    // Back-pressure: FIFO fills with two reads, third waits
    resp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_req(1'b0, 64'h4060_0100, 64'h0, 8'h0, 4'(i));
      dev_resp_rdata = 64'h1000 + 64'(i);
      step();
    end
    chk("bp_req_ready", 64'(req_ready), 64'h0);
    chk("bp_head_id", 64'(resp_id), 64'd0);
    resp_ready = 1'b1;
    req_id     = 4'd10;
    step();
    chk("bp_second_id", 64'(resp_id), 64'd3);
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Miss every cycle with concurrent drain
    for (int i = 0; i < 10; i++) begin
      drive_req(1'b0, 64'h0000_1000 + 64'(i), 64'h0, 8'h0, 4'(i));
      step();
      chk("pp_req_ready", 64'(req_ready), 64'h1);
    end
    req_valid = 1'b0;
    step();
    step();

    // Reset during CAPTURE
    drive_req(1'b0, 64'h4060_0020, 64'h0, 8'h0, 4'd9);
    step();
    req_valid = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    reset_n = 1'b1;
    #1;
    chk("rst_release_ready", 64'(req_ready), 64'h1);
    step();
    step();
    chk("rst_no_stale", 64'(resp_valid), 64'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      req_valid      = ($urandom_range(0, 2) != 0);
      req_wen        = $urandom_range(0, 1) == 1;
      req_addr       = pick_addr();
      req_wdata      = rand64();
      req_wmask      = 8'($urandom());
      req_id         = 4'($urandom());
      resp_ready     = ($urandom_range(0, 9) < 7);
      dev_resp_rdata = rand64();
      reset_n        = ($urandom_range(0, 299) != 0);
      step();
    end
    reset_n   = 1'b1;
    req_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
